// File: rtl/venus_soc_pkg.sv
// venus_soc_pkg: shared AXI4 bundle types and the memory arbiter
// FSM encodings used across the SoC fabric.
package venus_soc_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ax_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    awvalid;
        axi_w_t  w;
        logic    wvalid;
        logic    bready;
        axi_ax_t ar;
        logic    arvalid;
        logic    rready;
    } axi_req_t;

    typedef struct packed {
        logic   awready;
        logic   arready;
        logic   wready;
        axi_b_t b;
        logic   bvalid;
        axi_r_t r;
        logic   rvalid;
    } axi_resp_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first
// requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW:0] cand;

    // Scan downward so the candidate closest to ptr is written last.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (req[cand[IW-1:0]]) begin
                gnt_idx   = cand[IW-1:0];
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: shares one AXI4 memory port between NUM_MST
// masters, with independent round-robin read and write sequencers.
module axi_mem_arbiter
    import venus_soc_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int IDX_W   = $clog2(NUM_MST)
) (
    input  logic      aclk,
    input  logic      areset,
    input  axi_req_t  slv_req_i  [NUM_MST],
    output axi_resp_t slv_resp_o [NUM_MST],
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i
);

    wr_state_e        wr_state;
    rd_state_e        rd_state;
    logic [IDX_W-1:0] wr_gnt;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_gnt;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] aw_idx;
    logic [IDX_W-1:0] ar_idx;
    logic             aw_any;
    logic             ar_any;
    logic [NUM_MST-1:0] aw_req;
    logic [NUM_MST-1:0] ar_req;
    logic aw_hs;
    logic w_done;
    logic b_hs;
    logic ar_hs;
    logic r_done;

    function automatic logic [IDX_W-1:0] inc_ptr(
        input logic [IDX_W-1:0] p
    );
        return (p == IDX_W'(NUM_MST - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            aw_req[i] = slv_req_i[i].awvalid;
            ar_req[i] = slv_req_i[i].arvalid;
        end
    end

    rr_arbiter #(.N(NUM_MST), .IW(IDX_W)) u_wr_arb (
        .req       (aw_req),
        .ptr       (wr_ptr),
        .gnt_idx   (aw_idx),
        .gnt_valid (aw_any)
    );

    rr_arbiter #(.N(NUM_MST), .IW(IDX_W)) u_rd_arb (
        .req       (ar_req),
        .ptr       (rd_ptr),
        .gnt_idx   (ar_idx),
        .gnt_valid (ar_any)
    );

    assign aw_hs  = mst_req_o.awvalid & mst_resp_i.awready;
    assign w_done = mst_req_o.wvalid & mst_resp_i.wready
                  & mst_req_o.w.last;
    assign b_hs   = mst_resp_i.bvalid & mst_req_o.bready;
    assign ar_hs  = mst_req_o.arvalid & mst_resp_i.arready;
    assign r_done = mst_resp_i.rvalid & mst_req_o.rready
                  & mst_resp_i.r.last;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state <= WR_IDLE;
            wr_gnt   <= '0;
            wr_ptr   <= '0;
        end else begin
            unique case (wr_state)
                WR_IDLE: if (aw_any) begin
                    wr_gnt   <= aw_idx;
                    wr_state <= WR_ADDR;
                end
                WR_ADDR: if (aw_hs)  wr_state <= WR_DATA;
                WR_DATA: if (w_done) wr_state <= WR_RESP;
                WR_RESP: if (b_hs) begin
                    wr_state <= WR_IDLE;
                    wr_ptr   <= inc_ptr(wr_gnt);
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state <= RD_IDLE;
            rd_gnt   <= '0;
            rd_ptr   <= '0;
        end else begin
            unique case (rd_state)
                RD_IDLE: if (ar_any) begin
                    rd_gnt   <= ar_idx;
                    rd_state <= RD_ADDR;
                end
                RD_ADDR: if (ar_hs) rd_state <= RD_DATA;
                RD_DATA: if (r_done) begin
                    rd_state <= RD_IDLE;
                    rd_ptr   <= inc_ptr(rd_gnt);
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Only the latched grant is routed; IDLE exposes no ready at all.
    always_comb begin
        mst_req_o  = '0;
        slv_resp_o = '{default: '0};
        unique case (wr_state)
            WR_ADDR: begin
                mst_req_o.aw      = slv_req_i[wr_gnt].aw;
                mst_req_o.awvalid = slv_req_i[wr_gnt].awvalid;
                slv_resp_o[wr_gnt].awready = mst_resp_i.awready;
            end
            WR_DATA: begin
                mst_req_o.w      = slv_req_i[wr_gnt].w;
                mst_req_o.wvalid = slv_req_i[wr_gnt].wvalid;
                slv_resp_o[wr_gnt].wready = mst_resp_i.wready;
            end
            WR_RESP: begin
                mst_req_o.bready = slv_req_i[wr_gnt].bready;
                slv_resp_o[wr_gnt].b      = mst_resp_i.b;
                slv_resp_o[wr_gnt].bvalid = mst_resp_i.bvalid;
            end
            default: ;
        endcase
        unique case (rd_state)
            RD_ADDR: begin
                mst_req_o.ar      = slv_req_i[rd_gnt].ar;
                mst_req_o.arvalid = slv_req_i[rd_gnt].arvalid;
                slv_resp_o[rd_gnt].arready = mst_resp_i.arready;
            end
            RD_DATA: begin
                mst_req_o.rready = slv_req_i[rd_gnt].rready;
                slv_resp_o[rd_gnt].r      = mst_resp_i.r;
                slv_resp_o[rd_gnt].rvalid = mst_resp_i.rvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: directed bench for a 3-master arbiter in front
// of a small behavioural AXI4 memory.
module tb_axi_mem_arbiter;
    import venus_soc_pkg::*;

    localparam int NM  = 3;
    localparam int LIM = 200;

    logic      aclk = 1'b0;
    logic      areset;
    axi_req_t  slv_req  [NM];
    axi_resp_t slv_resp [NM];
    axi_req_t  mst_req;
    axi_resp_t mst_resp;

    int compared   = 0;
    int mismatched = 0;

    always #5 aclk = ~aclk;

    axi_mem_arbiter #(.NUM_MST(NM)) u_dut (
        .aclk       (aclk),
        .areset     (areset),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    // Behavioural memory: one write and one read burst at a time.
    logic [31:0] mem [1024];
    logic        w_busy, b_pend, r_busy;
    logic [31:0] waddr, raddr;
    logic [3:0]  bid, rid;
    logic [7:0]  rlen, rcnt;

    always_comb begin
        mst_resp          = '0;
        mst_resp.awready  = !w_busy;
        mst_resp.wready   = w_busy && !b_pend;
        mst_resp.bvalid   = b_pend;
        mst_resp.b.id     = bid;
        mst_resp.b.resp   = RESP_OKAY;
        mst_resp.arready  = !r_busy;
        mst_resp.rvalid   = r_busy;
        mst_resp.r.id     = rid;
        mst_resp.r.data   = mem[raddr[11:2]];
        mst_resp.r.resp   = RESP_OKAY;
        mst_resp.r.last   = (rcnt == rlen);
    end

    always @(posedge aclk) begin
        if (!areset && mst_req.wvalid && mst_resp.wready)
            mem[waddr[11:2]] <= mst_req.w.data;
    end

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_busy <= 1'b0; b_pend <= 1'b0; waddr <= '0; bid <= '0;
            r_busy <= 1'b0; raddr <= '0; rid <= '0;
            rlen <= '0; rcnt <= '0;
        end else begin
            if (mst_req.awvalid && mst_resp.awready) begin
                w_busy <= 1'b1;
                waddr  <= mst_req.aw.addr;
                bid    <= mst_req.aw.id;
            end
            if (mst_req.wvalid && mst_resp.wready) begin
                waddr <= waddr + 32'd4;
                if (mst_req.w.last) b_pend <= 1'b1;
            end
            if (b_pend && mst_req.bready) begin
                b_pend <= 1'b0;
                w_busy <= 1'b0;
            end
            if (mst_req.arvalid && mst_resp.arready) begin
                r_busy <= 1'b1;
                raddr  <= mst_req.ar.addr;
                rid    <= mst_req.ar.id;
                rlen   <= mst_req.ar.len;
                rcnt   <= '0;
            end
            if (r_busy && mst_req.rready) begin
                raddr <= raddr + 32'd4;
                rcnt  <= rcnt + 8'd1;
                if (rcnt == rlen) r_busy <= 1'b0;
            end
        end
    end

    logic [1:0]  word [8];
    logic [1:0]  rord [8];
    int          wseq = 0;
    int          rseq = 0;
    logic [31:0] rbuf [NM][16];
    int          rcnt_m [NM];
    int          rlast_idx [NM];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int ch, input logic [1:0] m);
        case (ch)
            0:       return slv_resp[m].awready;
            1:       return slv_resp[m].wready;
            2:       return slv_resp[m].bvalid;
            3:       return slv_resp[m].arready;
            default: return 1'b0;
        endcase
    endfunction

    // Called at a negedge; returns at +1 with the handshake armed.
    task automatic wait_rdy(input string tag, input int ch,
                            input logic [1:0] m);
        int n;
        n = 0;
        #1;
        while (!sel(ch, m) && n < LIM) begin
            @(negedge aclk);
            #1;
            n++;
        end
        chk({tag, "_wait"}, 64'(n < LIM), 64'd1);
    endtask

    task automatic wr(input logic [1:0] m, input logic [31:0] addr,
                      input logic [7:0] len, input logic [31:0] seed);
        logic [3:0] id;
        logic       others;
        id = {2'b10, m};
        slv_req[m].aw       = '0;
        slv_req[m].aw.id    = id;
        slv_req[m].aw.addr  = addr;
        slv_req[m].aw.len   = len;
        slv_req[m].aw.size  = 3'd2;
        slv_req[m].aw.burst = 2'b01;
        slv_req[m].awvalid  = 1'b1;
        wait_rdy("aw", 0, m);
        if (wseq < 8) word[wseq] = m;
        wseq++;
        @(negedge aclk);
        slv_req[m].awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            slv_req[m].w.data = seed + 32'(b);
            slv_req[m].w.strb = 4'hF;
            slv_req[m].w.last = (b == int'(len));
            slv_req[m].wvalid = 1'b1;
            wait_rdy("w", 1, m);
            @(negedge aclk);
        end
        slv_req[m].wvalid = 1'b0;
        slv_req[m].w      = '0;
        slv_req[m].bready = 1'b1;
        wait_rdy("b", 2, m);
        others = 1'b0;
        for (int i = 0; i < NM; i++)
            if (i != int'(m)) others |= slv_resp[i].bvalid;
        chk("bresp", 64'(slv_resp[m].b.resp), 64'(RESP_OKAY));
        chk("bid", 64'(slv_resp[m].b.id), 64'(id));
        chk("b_route", 64'(others), 64'd0);
        @(negedge aclk);
        slv_req[m].bready = 1'b0;
    endtask

    task automatic rd(input logic [1:0] m, input logic [31:0] addr,
                      input logic [7:0] len, input bit bp);
        int   cnt, cyc;
        logic done, rr;
        slv_req[m].ar       = '0;
        slv_req[m].ar.id    = {2'b01, m};
        slv_req[m].ar.addr  = addr;
        slv_req[m].ar.len   = len;
        slv_req[m].ar.size  = 3'd2;
        slv_req[m].ar.burst = 2'b01;
        slv_req[m].arvalid  = 1'b1;
        wait_rdy("ar", 3, m);
        if (rseq < 8) rord[rseq] = m;
        rseq++;
        @(negedge aclk);
        slv_req[m].arvalid = 1'b0;
        cnt = 0; cyc = 0; done = 1'b0;
        rlast_idx[m] = -1;
        while (!done && cyc < LIM) begin
            rr = bp ? (cyc % 2 == 0) : 1'b1;
            slv_req[m].rready = rr;
            #1;
            if (bp) chk("rready_mirror", 64'(mst_req.rready), 64'(rr));
            if (slv_resp[m].rvalid && rr && cnt < 16) begin
                rbuf[m][cnt] = slv_resp[m].r.data;
                if (slv_resp[m].r.last) begin
                    done = 1'b1;
                    rlast_idx[m] = cnt;
                end
                cnt++;
            end
            @(negedge aclk);
            cyc++;
        end
        slv_req[m].rready = 1'b0;
        rcnt_m[m] = cnt;
        chk("r_done", 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        for (int i = 0; i < NM; i++) slv_req[i] = '0;
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_mst_vld", 64'({mst_req.awvalid, mst_req.wvalid,
            mst_req.bready, mst_req.arvalid, mst_req.rready}), 64'd0);
        chk("rst_mst_addr", 64'(mst_req.aw.addr), 64'd0);
        for (int i = 0; i < NM; i++)
            chk("rst_slv_rdy", 64'({slv_resp[i].awready,
                slv_resp[i].wready, slv_resp[i].bvalid,
                slv_resp[i].arready, slv_resp[i].rvalid}), 64'd0);
        chk("rst_ptrs", 64'({u_dut.wr_ptr, u_dut.rd_ptr}), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);

        // Single write from master 0, AW visible one cycle later.
        fork
            wr(2'd0, 32'h100, 8'd3, 32'h1000);
            begin
                #1;
                chk("aw_idle_rdy", 64'(slv_resp[0].awready), 64'd0);
                chk("aw_idle_fwd", 64'(mst_req.awvalid), 64'd0);
                @(negedge aclk);
                #2;
                chk("aw_fwd", 64'(mst_req.awvalid), 64'd1);
                chk("aw_addr", 64'(mst_req.aw.addr), 64'h100);
                chk("aw_len", 64'(mst_req.aw.len), 64'd3);
                chk("aw_rdy_other", 64'(slv_resp[1].awready), 64'd0);
            end
        join
        #1;
        chk("wr_idle", 64'(u_dut.wr_state), 64'(WR_IDLE));

        // Two simultaneous reads: 0 then 1; then all three from ptr 2.
        rseq = 0;
        fork
            rd(2'd0, 32'h100, 8'd3, 1'b0);
            rd(2'd1, 32'h100, 8'd3, 1'b0);
        join
        chk("rd_first", 64'(rord[0]), 64'd0);
        chk("rd_second", 64'(rord[1]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rd0_data", 64'(rbuf[0][i]), 64'(32'h1000 + i));
            chk("rd1_data", 64'(rbuf[1][i]), 64'(32'h1000 + i));
        end
        rseq = 0;
        fork
            rd(2'd0, 32'h100, 8'd0, 1'b0);
            rd(2'd1, 32'h100, 8'd0, 1'b0);
            rd(2'd2, 32'h100, 8'd0, 1'b0);
        join
        chk("rr_order0", 64'(rord[0]), 64'd2);
        chk("rr_order1", 64'(rord[1]), 64'd0);
        chk("rr_order2", 64'(rord[2]), 64'd1);

        // Concurrent write (master 0) and read (master 1).
        wr(2'd2, 32'h300, 8'd7, 32'hA000);
        fork
            wr(2'd0, 32'h400, 8'd7, 32'hB000);
            rd(2'd1, 32'h300, 8'd7, 1'b0);
        join
        chk("cc_rcnt", 64'(rcnt_m[1]), 64'd8);
        chk("cc_rlast", 64'(rlast_idx[1]), 64'd7);
        for (int i = 0; i < 8; i++)
            chk("cc_rdata", 64'(rbuf[1][i]), 64'(32'hA000 + i));
        rd(2'd2, 32'h400, 8'd7, 1'b0);
        for (int i = 0; i < 8; i++)
            chk("cc_wdata", 64'(rbuf[2][i]), 64'(32'hB000 + i));

        // rready backpressure from master 1.
        rd(2'd1, 32'h300, 8'd7, 1'b1);
        chk("bp_rcnt", 64'(rcnt_m[1]), 64'd8);
        chk("bp_rlast", 64'(rlast_idx[1]), 64'd7);
        for (int i = 0; i < 8; i++)
            chk("bp_rdata", 64'(rbuf[1][i]), 64'(32'hA000 + i));

        // Asynchronous reset during beat 2 of a 4-beat write.
        slv_req[0].aw      = '0;
        slv_req[0].aw.addr = 32'h500;
        slv_req[0].aw.len  = 8'd3;
        slv_req[0].awvalid = 1'b1;
        wait_rdy("aw5", 0, 2'd0);
        @(negedge aclk);
        slv_req[0].awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            slv_req[0].w.data = 32'h5000 + 32'(b);
            slv_req[0].wvalid = 1'b1;
            wait_rdy("w5", 1, 2'd0);
            @(negedge aclk);
        end
        slv_req[0].w.data = 32'h5002;
        slv_req[0].wvalid = 1'b1;
        #1;
        chk("pre_rst_wvalid", 64'(mst_req.wvalid), 64'd1);
        areset = 1'b1;
        #1;
        chk("midrst_mst_vld", 64'({mst_req.awvalid, mst_req.wvalid,
            mst_req.bready, mst_req.arvalid, mst_req.rready}), 64'd0);
        chk("midrst_slv0", 64'({slv_resp[0].awready, slv_resp[0].wready,
            slv_resp[0].bvalid}), 64'd0);
        chk("midrst_state", 64'(u_dut.wr_state), 64'(WR_IDLE));
        slv_req[0] = '0;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        wr(2'd1, 32'h600, 8'd0, 32'hC000);
        rd(2'd2, 32'h600, 8'd0, 1'b0);
        chk("post_rst_data", 64'(rbuf[2][0]), 64'hC000);

        // Three masters writing back to back from a fresh pointer.
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        wseq = 0;
        fork
            begin
                wr(2'd0, 32'h700, 8'd1, 32'hD000);
                wr(2'd0, 32'h710, 8'd1, 32'hD010);
            end
            begin
                wr(2'd1, 32'h720, 8'd1, 32'hD020);
                wr(2'd1, 32'h730, 8'd1, 32'hD030);
            end
            begin
                wr(2'd2, 32'h740, 8'd1, 32'hD040);
                wr(2'd2, 32'h750, 8'd1, 32'hD050);
            end
        join
        chk("wr_count", 64'(wseq), 64'd6);
        for (int i = 0; i < 6; i++)
            chk("gnt_order", 64'(word[i]), 64'(i % 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
